// File: rtl/star_pkg.sv
// Shared definitions for the star-image search stages: image geometry,
// pixel format and the scan FSM encoding used by the edge-finder controllers.
package star_pkg;

  localparam int X_SZ      = 3;
  localparam int Y_SZ      = 3;
  localparam int ADDR_SZ   = 6;
  localparam int COL_SZ    = 3;
  localparam int WIDTH     = 6;
  localparam int HEIGHT    = 6;
  localparam int N         = WIDTH * HEIGHT;

  localparam logic [COL_SZ-1:0] THRESHOLD = '0;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_TOP,
    SCAN_BOTTOM,
    DONE,
    EMPTY
  } scanState_t;

  // Any pixel that differs from the background value belongs to the star.
  function automatic logic isStar(input logic [COL_SZ-1:0] pix);
    return pix != THRESHOLD;
  endfunction

endpackage

// File: rtl/address_translator.sv
// Maps an (x, y) image coordinate onto the linear pixel RAM address
// y*WIDTH + x. All arithmetic is zero-extended to the address width.
module address_translator
  import star_pkg::*;
(
  input  logic [X_SZ-1:0]    x,
  input  logic [Y_SZ-1:0]    y,
  output logic [ADDR_SZ-1:0] mem_address
);

  // Row stride times row plus column; coordinates are always in range.
  assign mem_address = ADDR_SZ'(y) * ADDR_SZ'(WIDTH) + ADDR_SZ'(x);

endmodule

// File: rtl/find_top_bottom.sv
// Scans the star image one pixel per clock: forward from the top-left corner
// to find the first star row and its column, then backward from the
// bottom-right corner to find the last star row. Results are handed to the
// edge finders with a single-cycle top_and_bottom_found pulse.
module find_top_bottom
  import star_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_SZ-1:0] mem_addr,
  input  logic [COL_SZ-1:0]  pix_val,
  output logic [Y_SZ-1:0]    most_top,
  output logic [Y_SZ-1:0]    most_bottom,
  output logic [X_SZ-1:0]    mid_pix,
  output logic               top_and_bottom_found,
  output logic               no_star,
  output logic               busy
);

  localparam logic [X_SZ-1:0] X_LAST = X_SZ'(WIDTH - 1);
  localparam logic [Y_SZ-1:0] Y_LAST = Y_SZ'(HEIGHT - 1);

  scanState_t      state, stateNext;
  logic [X_SZ-1:0] scanX;
  logic [Y_SZ-1:0] scanY;
  logic            rdValid;
  logic [X_SZ-1:0] rdX;
  logic [Y_SZ-1:0] rdY;
  logic            hit;
  logic            rdLast;
  logic            atFirst;
  logic            atLast;

  // The issued address follows the scan counters; idx is mem_addr itself.
  address_translator addrXlate (
    .x           (scanX),
    .y           (scanY),
    .mem_address (mem_addr)
  );

  assign hit     = rdValid && isStar(pix_val);
  assign rdLast  = rdValid && (rdX == X_LAST) && (rdY == Y_LAST);
  assign atFirst = (scanX == '0) && (scanY == '0);
  assign atLast  = (scanX == X_LAST) && (scanY == Y_LAST);

  assign top_and_bottom_found = (state == DONE);
  assign busy                 = (state == SCAN_TOP) || (state == SCAN_BOTTOM);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic: a hit always wins over the end-of-image condition.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:        if (start) stateNext = SCAN_TOP;
      SCAN_TOP:    if (hit) stateNext = SCAN_BOTTOM;
                   else if (rdLast) stateNext = EMPTY;
      SCAN_BOTTOM: if (hit) stateNext = DONE;
      DONE:        stateNext = IDLE;
      EMPTY:       stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
  end

  // Scan counters and read pipeline; rdX/rdY tag the pixel arriving next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scanX   <= '0;
      scanY   <= '0;
      rdValid <= 1'b0;
      rdX     <= '0;
      rdY     <= '0;
    end else begin
      case (state)
        SCAN_TOP: begin
          if (hit) begin
            // Restart from the last pixel; the fetch in flight is dropped.
            scanX   <= X_LAST;
            scanY   <= Y_LAST;
            rdValid <= 1'b0;
          end else begin
            rdValid <= !rdLast;
            rdX     <= scanX;
            rdY     <= scanY;
            if (!atLast) begin
              if (scanX == X_LAST) begin
                scanX <= '0;
                scanY <= scanY + Y_SZ'(1);
              end else begin
                scanX <= scanX + X_SZ'(1);
              end
            end
          end
        end
        SCAN_BOTTOM: begin
          if (hit) begin
            rdValid <= 1'b0;
          end else begin
            rdValid <= 1'b1;
            rdX     <= scanX;
            rdY     <= scanY;
            if (!atFirst) begin
              if (scanX == '0) begin
                scanX <= X_LAST;
                scanY <= scanY - Y_SZ'(1);
              end else begin
                scanX <= scanX - X_SZ'(1);
              end
            end
          end
        end
        default: begin
          scanX   <= '0;
          scanY   <= '0;
          rdValid <= 1'b0;
        end
      endcase
    end
  end

  // Result registers: cleared on an accepted start, latched on hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      most_top    <= '0;
      most_bottom <= '0;
      mid_pix     <= '0;
      no_star     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        most_top    <= '0;
        most_bottom <= '0;
        mid_pix     <= '0;
        no_star     <= 1'b0;
      end
      if (state == SCAN_TOP && hit) begin
        most_top <= rdY;
        mid_pix  <= rdX;
      end
      if (state == SCAN_TOP && !hit && rdLast) begin
        no_star <= 1'b1;
      end
      if (state == SCAN_BOTTOM && hit) begin
        most_bottom <= rdY;
      end
    end
  end

endmodule

// File: tb/tb_find_top_bottom.sv
// Directed bench for find_top_bottom with a synchronous-read pixel RAM model
// and a scoreboard of expected scan results.
module tb_find_top_bottom;
  import star_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ADDR_SZ-1:0] mem_addr;
  logic [COL_SZ-1:0]  pix_val;
  logic [Y_SZ-1:0]    most_top;
  logic [Y_SZ-1:0]    most_bottom;
  logic [X_SZ-1:0]    mid_pix;
  logic               top_and_bottom_found;
  logic               no_star;
  logic               busy;

  find_top_bottom dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .mem_addr             (mem_addr),
    .pix_val              (pix_val),
    .most_top             (most_top),
    .most_bottom          (most_bottom),
    .mid_pix              (mid_pix),
    .top_and_bottom_found (top_and_bottom_found),
    .no_star              (no_star),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  // Read-only image RAM with a one-cycle registered read.
  logic [COL_SZ-1:0] img [N];
  always @(posedge clk) pix_val <= img[mem_addr];

  typedef struct {
    int top;
    int bottom;
    int mid;
    int noStar;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clearImg();
    for (int i = 0; i < N; i++) img[i] = '0;
  endtask

  task automatic setPix(input int x, input int y, input int v);
    img[y * WIDTH + x] = COL_SZ'(v);
  endtask

  // Reference: first and last non-background linear index of the image.
  task automatic pushExpected();
    exp_t e;
    int kt = -1;
    int kb = -1;
    for (int i = 0; i < N; i++) begin
      if (img[i] != THRESHOLD) begin
        if (kt < 0) kt = i;
        kb = i;
      end
    end
    if (kt < 0) begin
      e = '{top: 0, bottom: 0, mid: 0, noStar: 1, cyc: N + 2};
    end else begin
      e = '{top: kt / WIDTH, bottom: kb / WIDTH, mid: kt % WIDTH,
            noStar: 0, cyc: kt + (N - 1 - kb) + 5};
    end
    sb.push_back(e);
  endtask

  // Cycle 1 begins at the edge that samples start.
  task automatic runScan(input string name);
    exp_t e;
    int   cyc;
    int   pulses;
    bit   seen;
    pushExpected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({name, ".busy"}, int'(busy), 1);
    check({name, ".clr"}, int'({most_top, most_bottom, mid_pix, no_star}), 0);
    seen = 1'b0;
    while (!seen && cyc <= 100) begin
      if (top_and_bottom_found || no_star) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    check({name, ".done"}, int'(seen), 1);
    if (seen) begin
      check({name, ".cycle"}, cyc, e.cyc);
      check({name, ".found"}, int'(top_and_bottom_found), 1 - e.noStar);
      check({name, ".nostar"}, int'(no_star), e.noStar);
      check({name, ".busyEnd"}, int'(busy), 0);
      check({name, ".top"}, int'(most_top), e.top);
      check({name, ".bottom"}, int'(most_bottom), e.bottom);
      check({name, ".mid"}, int'(mid_pix), e.mid);
      $display("scan %s: cycle=%0d top=%0d bottom=%0d mid=%0d no_star=%0d",
               name, cyc, most_top, most_bottom, mid_pix, no_star);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (top_and_bottom_found) pulses++;
    end
    check({name, ".pulseWidth"}, pulses, 0);
    check({name, ".holdTop"}, int'(most_top), e.top);
    check({name, ".holdNoStar"}, int'(no_star), e.noStar);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clearImg();
    repeat (3) @(negedge clk);
    check("reset.outs", int'({most_top, most_bottom, mid_pix, top_and_bottom_found,
                              no_star, busy}), 0);
    check("reset.addr", int'(mem_addr), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single pixel at (2,3)
    clearImg();
    setPix(2, 3, 5);
    runScan("single");

    // Plus shape
    clearImg();
    setPix(2, 1, 1); setPix(1, 2, 2); setPix(2, 2, 3); setPix(3, 2, 4); setPix(2, 3, 7);
    runScan("plus");

    // Empty image
    clearImg();
    runScan("empty");

    // Opposite corners
    clearImg();
    setPix(0, 0, 1); setPix(5, 5, 1);
    runScan("corners");

    // Ignored restart in SCAN_TOP, then reset during SCAN_BOTTOM
    clearImg();
    setPix(4, 1, 5); setPix(0, 5, 3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort.busyAfterRestart", int'(busy), 1);
    repeat (11) @(negedge clk);
    check("abort.topBeforeReset", int'(most_top), 1);
    check("abort.midBeforeReset", int'(mid_pix), 4);
    check("abort.busyBeforeReset", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort.outsAsync", int'({most_top, most_bottom, mid_pix, top_and_bottom_found,
                                   no_star, busy}), 0);
    $display("scan abort: reset asserted mid scan, outputs cleared");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    runScan("rescan");

    // Back-to-back scans with fresh images
    clearImg();
    setPix(5, 0, 2); setPix(3, 4, 6);
    runScan("b2bA");
    clearImg();
    setPix(1, 5, 4);
    runScan("b2bB");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
